// File: rtl/pixl_bus_reader_if.sv
// pixl_bus_reader_if: Atari bus pins and fabric push port for the pixl read responder.
// The slave modport is the responder's view; the master modport is the view of
// whatever drives the Atari bus and the fabric producer.
interface pixl_bus_reader_if;
    logic        a8_clk;
    logic [15:0] a8_addr;
    logic        a8_rw_n;
    logic [7:0]  a8_data_in;
    logic [7:0]  a8_data_out;
    logic        a8_data_oe;
    logic        push_valid;
    logic [7:0]  push_data;
    logic        push_ready;

    modport slave (
        input  a8_clk,
        input  a8_addr,
        input  a8_rw_n,
        input  a8_data_in,
        output a8_data_out,
        output a8_data_oe,
        input  push_valid,
        input  push_data,
        output push_ready
    );

    modport master (
        output a8_clk,
        output a8_addr,
        output a8_rw_n,
        output a8_data_in,
        input  a8_data_out,
        input  a8_data_oe,
        output push_valid,
        output push_data,
        input  push_ready
    );
endinterface

// File: rtl/pixl_bus_reader.sv
// pixl_bus_reader: Atari-side read responder for the pixl cartridge.
// Answers 6502 reads in the BASE_PAGE register window from a small FIFO that
// fabric producers fill through a valid/ready push port.
//   offset 0x00 STATUS : {not_empty, overflow, 1'b0, count[4:0]}; a write with
//                        bit6 set clears overflow
//   offset 0x01 DATA   : FIFO head (popped at the end of the cycle), or EMPTY_BYTE
//   offset 0x02 RDCOUNT: 8-bit count of DATA reads that popped a byte; present
//                        only when the PIXL_RD_COUNT_EN macro is defined
// phi2 is asynchronous; it is resynchronised with two flops and edge-detected
// with a third, so bus edges act on the fabric 3 clk after they occur.
module pixl_bus_reader #(
    parameter logic [7:0] BASE_PAGE  = 8'hD5,
    parameter int         DEPTH      = 16,
    parameter logic [7:0] EMPTY_BYTE = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    pixl_bus_reader_if.slave bus
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIT  = 2'd1,
        ST_MISS = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic        r_phi_meta;
    logic        r_phi_sync;
    logic        r_phi_prev;

    state_t      r_state;
    logic        r_data_oe;
    logic [7:0]  r_data_out;
    logic [15:0] r_addr;
    logic        r_rw_n;
    logic        r_was_nonempty;

    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [4:0]  r_count;
    logic        r_push_ready;
    logic        r_ovf;

`ifdef PIXL_RD_COUNT_EN
    logic [7:0]  r_rd_count;
`endif

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic        w_phi_rise;
    logic        w_phi_fall;
    logic        w_in_page;
    logic [7:0]  w_off;
    logic        w_rd_hit;
    logic [7:0]  w_status;
    logic [7:0]  w_head;
    logic [7:0]  w_rd_value;
    state_t      w_state_nxt;
    logic        w_load;
    logic        w_pop;
    logic        w_ovf_clr;
    logic        w_oe_nxt;
    logic        w_push;
    logic        w_ovf_set;
    logic [4:0]  w_count_nxt;
    logic        w_lat_data_rd;
    logic        w_lat_stat_wr;

    assign w_phi_rise = r_phi_sync & ~r_phi_prev;
    assign w_phi_fall = ~r_phi_sync & r_phi_prev;

    assign w_in_page  = (bus.a8_addr[15:8] == BASE_PAGE);
    assign w_off      = bus.a8_addr[7:0];
    assign w_status   = {(r_count != 5'd0), r_ovf, 1'b0, r_count};
    assign w_head     = r_mem[r_rptr];

    // Decoded meaning of the cycle latched at the rise
    assign w_lat_data_rd = r_rw_n  & (r_addr == {BASE_PAGE, 8'h01});
    assign w_lat_stat_wr = ~r_rw_n & (r_addr == {BASE_PAGE, 8'h00});

    assign w_push    = bus.push_valid & r_push_ready;
    assign w_ovf_set = bus.push_valid & ~r_push_ready;

    assign bus.a8_data_out = r_data_out;
    assign bus.a8_data_oe  = r_data_oe;
    assign bus.push_ready  = r_push_ready;

    // Resynchronise phi2; flops reset high so phi2 high at reset release is not a rise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phi_meta <= 1'b1;
            r_phi_sync <= 1'b1;
            r_phi_prev <= 1'b1;
        end else begin
            r_phi_meta <= bus.a8_clk;
            r_phi_sync <= r_phi_meta;
            r_phi_prev <= r_phi_sync;
        end
    end

    // Read decode of the live address and the byte a hit would drive
    always_comb begin
        w_rd_hit   = 1'b0;
        w_rd_value = w_status;
        if (w_in_page && bus.a8_rw_n) begin
            case (w_off)
                8'h00: begin
                    w_rd_hit   = 1'b1;
                    w_rd_value = w_status;
                end
                8'h01: begin
                    w_rd_hit   = 1'b1;
                    w_rd_value = (r_count != 5'd0) ? w_head : EMPTY_BYTE;
                end
`ifdef PIXL_RD_COUNT_EN
                8'h02: begin
                    w_rd_hit   = 1'b1;
                    w_rd_value = r_rd_count;
                end
`endif
                default: begin
                    w_rd_hit   = 1'b0;
                    w_rd_value = w_status;
                end
            endcase
        end else begin
            w_rd_hit   = 1'b0;
            w_rd_value = w_status;
        end
    end

    // Bus FSM next state plus the end-of-cycle pop and overflow-clear strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        w_ovf_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_phi_rise) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_rd_hit ? ST_HIT : ST_MISS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HIT, ST_MISS: begin
                if (w_phi_fall) begin
                    w_state_nxt = ST_IDLE;
                    w_pop       = w_lat_data_rd & r_was_nonempty;
                    w_ovf_clr   = w_lat_stat_wr & ((bus.a8_data_in & 8'h40) != 8'h00);
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_oe_nxt = (w_state_nxt == ST_HIT);
    end

    // FSM state, latched cycle info and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_data_oe      <= 1'b0;
            r_data_out     <= 8'h00;
            r_addr         <= 16'h0000;
            r_rw_n         <= 1'b1;
            r_was_nonempty <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_data_oe <= w_oe_nxt;
            if (w_load) begin
                r_addr         <= bus.a8_addr;
                r_rw_n         <= bus.a8_rw_n;
                r_was_nonempty <= (r_count != 5'd0);
                if (w_rd_hit) begin
                    r_data_out <= w_rd_value;
                end else begin
                    r_data_out <= r_data_out;
                end
            end else begin
                r_addr         <= r_addr;
                r_rw_n         <= r_rw_n;
                r_was_nonempty <= r_was_nonempty;
                r_data_out     <= r_data_out;
            end
        end
    end

    // FIFO occupancy after this clk's push and pop
    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 5'd1;
            2'b01:   w_count_nxt = r_count - 5'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.push_data;
        end
    end

    // FIFO pointers, count, ready flag and sticky overflow (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= 5'd0;
            r_push_ready <= 1'b1;
            r_ovf        <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count      <= w_count_nxt;
            r_push_ready <= (w_count_nxt != DEPTH_C);
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef PIXL_RD_COUNT_EN
    // Count of DATA reads that actually returned a FIFO byte; wraps at 256
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_count <= 8'h00;
        end else if (w_pop) begin
            r_rd_count <= r_rd_count + 8'h01;
        end
    end
`endif

endmodule

// File: doc/pixl_bus_reader.md
# pixl_bus_reader

Atari-side read responder for the pixl cartridge. It answers 6502 read cycles in a one-page register window by driving the data bus, serving bytes the FPGA fabric has pushed into a small FIFO. It is the return path complementing the bus snooper. It sits between fabric producers (push interface) and the Atari bus pins (a8_addr, a8_clk, a8_rw_n, a8_data) and drives the data-pin output enable.

## Interface
- BASE_PAGE, 8'hD5: a8_addr[15:8] value that selects the window.
- DEPTH, 16: FIFO depth; power of two, 2..16.
- EMPTY_BYTE, 8'h00: byte returned by a DATA read when the FIFO is empty.
- clk  in  1  fabric clock; must be ≥ 50 MHz.
- rst  in  1  synchronous, active-high reset.
- a8_clk  in  1  Atari phi2, asynchronous to clk.
- a8_addr  in  16  Atari address bus.
- a8_rw_n  in  1  1 = read, 0 = write.
- a8_data_in  in  8  Atari data bus, input side.
- a8_data_out  out  8  data driven on reads.
- a8_data_oe  out  1  data pin output enable; high = drive.
- push_valid  in  1  fabric byte offered.
- push_data  in  8  fabric byte.
- push_ready  out  1  high when the FIFO is not full.

## Operation
- phi2 path: a8_clk passes through a 2-flop synchronizer, then a 1-flop edge detector.
  - Synchronizer and detector flops reset to 1, so no false rise is seen if phi2 is high at reset release.
- Register window, decoded from a8_addr[7:0] inside BASE_PAGE:
  - 0x00 STATUS (read): bit7 = not-empty, bit6 = overflow (sticky), bit5 = 0, bits4:0 = FIFO count.
  - 0x01 DATA (read): returns the FIFO head, or EMPTY_BYTE when the FIFO is empty.
  - A write to 0x00 with a8_data_in[6] = 1 clears overflow.
  - All other offsets: not decoded, not driven.
- FSM states: IDLE, HIT, MISS.
- Transitions from IDLE on a synced phi2 rise:
  - Latch a8_addr, a8_rw_n and a STATUS snapshot.
  - Read that hits 0x00 or 0x01: go to HIT.
  - Anything else: go to MISS.
- HIT: a8_data_oe = 1 and a8_data_out holds the latched value. It is stable for the whole HIT state.
- MISS: outputs idle. For a write hit, latch a8_data_in on the fall.
- Any state, on a synced phi2 fall: return to IDLE, a8_data_oe = 0.
  - Pop only if the cycle was a DATA read and the FIFO was non-empty at the rise.
  - Apply the overflow clear if the cycle was a write to 0x00.
- FIFO:
  - Push when push_valid && push_ready.
  - push_valid while full: byte dropped, overflow set.
  - Push and pop in the same clk: both take effect, count unchanged.
  - A pop does not free space for a same-cycle push when full. push_ready is !full, registered from count.
  - Pointers wrap modulo DEPTH; count spans 0..DEPTH.
- Overflow: a set and a clear in the same clk resolve to set.

## Timing
- Reset values: a8_data_out = 8'h00, a8_data_oe = 0, push_ready = 1, FIFO empty, overflow = 0, FSM = IDLE.
- Rise latency: a8_data_oe rises 3 clk after a8_clk rises (2 sync + 1 detect).
- Fall latency: a8_data_oe falls 3 clk after a8_clk falls. The pop happens on that same clk edge.
- a8_data_out changes only on the clk where the FSM leaves IDLE.
- push_ready reflects a push or pop 1 clk later.
- rst asserted mid-cycle: on the next clk, a8_data_oe = 0, FSM = IDLE and the FIFO is cleared. The in-flight Atari cycle is abandoned; no pop and no clear are applied.
- phi2 glitches shorter than 2 clk may be missed. This is acceptable; a8_clk is a clean bus clock.

## Configuration
- PIXL_RD_COUNT_EN defined:
  - Offset 0x02 is decoded (read-only, HIT) and returns an 8-bit count of DATA reads that popped a byte.
  - The count wraps at 256 and resets to 0.
- PIXL_RD_COUNT_EN undefined: offset 0x02 is undecoded (MISS, never driven) and no counter logic is present.

## Test plan
- Reset, then STATUS read at $D500 → a8_data_oe high 3 clk after the phi2 rise, data 8'h00, low 3 clk after the fall.
- Push 8'hA5, 8'h3C, then two DATA reads at $D501 → bytes A5 then 3C; STATUS then reads 8'h00; one pop per read.
- Push 17 bytes with DEPTH = 16 → push_ready low after 16 pushes, 17th dropped; STATUS = 8'hD0. Then write 8'h40 to $D500 → STATUS = 8'h90.
- DATA read on an empty FIFO → EMPTY_BYTE driven, count stays 0. A read at $D601 or $D5FF → a8_data_oe never asserted.
- FIFO at count 5, push and pop on the same clk → count stays 5. rst asserted while HIT → a8_data_oe low next clk, count 0, and no drive until the next rise after rst drops.
- With PIXL_RD_COUNT_EN: three successful DATA pops, then a read at $D502 → 8'h03. Without the macro → $D502 is not driven.
